// File: rtl/adau1761_init.sv
// ADAU1761 power-up sequencer: walks a fixed register table and writes each
// entry over open-drain I2C, retrying NACKed writes, then raises enabled.
module adau1761_init #(
  parameter int unsigned CLK_DIV      = 62,
  parameter int unsigned STARTUP_WAIT = 2_000_000,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter logic [6:0]  DEV_ADDR     = 7'h38,
  parameter int unsigned NUM_WRITES   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          sda_i,
  output logic                          scl_oe,
  output logic                          sda_oe,
  output logic                          busy,
  output logic                          enabled,
  output logic                          error,
  output logic [$clog2(NUM_WRITES)-1:0] fail_index
);

  localparam int unsigned QW = $clog2(CLK_DIV);
  localparam int unsigned IW = $clog2(NUM_WRITES);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
  localparam int unsigned WW = $clog2(STARTUP_WAIT + 1);

  typedef enum logic [2:0] {
    S_WAIT, S_START, S_BYTE, S_STOP, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t          state;
  logic [QW-1:0]   q_cnt;
  logic [1:0]      phase;
  logic [3:0]      bit_cnt;
  logic [1:0]      byte_cnt;
  logic [IW-1:0]   index;
  logic [RW-1:0]   retry;
  logic            nack;
  logic [WW-1:0]   wait_cnt;
  logic            q_end;
  logic [23:0]     entry;
  logic [7:0]      tx_byte;
  logic            tx_bit;
  logic            scl_c;
  logic            sda_c;

  // Codec register table: {reg_addr[15:0], data[7:0]}
  function automatic logic [23:0] cfg_entry(input logic [IW-1:0] idx);
    logic [23:0] e;
    e = 24'h0;
    case (4'(idx))
      4'd0:  e = 24'h4000_01;  // clock control: core clock on
      4'd1:  e = 24'h400A_01;
      4'd2:  e = 24'h400B_05;
      4'd3:  e = 24'h400C_01;
      4'd4:  e = 24'h400D_05;
      4'd5:  e = 24'h4015_01;
      4'd6:  e = 24'h4016_00;
      4'd7:  e = 24'h4017_00;
      4'd8:  e = 24'h4019_13;
      4'd9:  e = 24'h401C_21;
      4'd10: e = 24'h401E_41;
      4'd11: e = 24'h4023_E7;
      4'd12: e = 24'h4024_E7;
      4'd13: e = 24'h4029_03;
      4'd14: e = 24'h402A_03;
      4'd15: e = 24'h40F9_7F;  // digital power / serial port clocks on
      default: e = 24'h0;
    endcase
    return e;
  endfunction

  assign q_end = (q_cnt == QW'(CLK_DIV - 1));
  assign entry = cfg_entry(index);

  always_comb begin
    tx_byte = {DEV_ADDR, 1'b0};
    case (byte_cnt)
      2'd1:    tx_byte = entry[23:16];
      2'd2:    tx_byte = entry[15:8];
      2'd3:    tx_byte = entry[7:0];
      default: tx_byte = {DEV_ADDR, 1'b0};
    endcase
  end

  // MSB first: bit_cnt 0..7 selects bit 7..0
  assign tx_bit = tx_byte[~bit_cnt[2:0]];

  // Sequencer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_WAIT;
      q_cnt      <= '0;
      phase      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      index      <= '0;
      retry      <= '0;
      nack       <= 1'b0;
      wait_cnt   <= '0;
      fail_index <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == WW'(STARTUP_WAIT - 1)) begin
            state <= S_START;
            index <= '0;
            retry <= '0;
            q_cnt <= '0;
            phase <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE, S_ERROR: begin
          if (start) begin
            state <= S_START;
            index <= '0;
            retry <= '0;
            q_cnt <= '0;
            phase <= '0;
          end
        end
        default: begin
          q_cnt <= q_end ? '0 : q_cnt + 1'b1;
          if (state == S_BYTE && bit_cnt == 4'd8 && phase == 2'd3 && q_cnt == '0)
            nack <= sda_i;
          if (q_end) begin
            phase <= phase + 1'b1;
            case (state)
              S_START: begin
                if (phase == 2'd1) begin
                  state    <= S_BYTE;
                  phase    <= '0;
                  bit_cnt  <= '0;
                  byte_cnt <= '0;
                  nack     <= 1'b0;
                end
              end
              S_BYTE: begin
                if (phase == 2'd3) begin
                  if (bit_cnt == 4'd8) begin
                    bit_cnt <= '0;
                    if (nack || byte_cnt == 2'd3) state <= S_STOP;
                    else byte_cnt <= byte_cnt + 1'b1;
                  end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                  end
                end
              end
              S_STOP: begin
                if (phase == 2'd2) begin
                  state <= S_GAP;
                  phase <= '0;
                end
              end
              S_GAP: begin
                if (phase == 2'd3) begin
                  if (nack) begin
                    if (retry < RW'(MAX_RETRIES)) begin
                      retry <= retry + 1'b1;
                      state <= S_START;
                    end else begin
                      fail_index <= index;
                      state      <= S_ERROR;
                    end
                  end else if (index == IW'(NUM_WRITES - 1)) begin
                    state <= S_DONE;
                  end else begin
                    index <= index + 1'b1;
                    retry <= '0;
                    state <= S_START;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Line drive for the current state/phase; registered below
  always_comb begin
    scl_c = 1'b0;
    sda_c = 1'b0;
    case (state)
      S_START: begin
        sda_c = 1'b1;
        scl_c = (phase == 2'd1);
      end
      S_BYTE: begin
        scl_c = ~phase[1];
        sda_c = (bit_cnt == 4'd8) ? 1'b0 : ~tx_bit;
      end
      S_STOP: begin
        scl_c = (phase == 2'd0);
        sda_c = (phase != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      enabled <= 1'b0;
      error   <= 1'b0;
    end else begin
      scl_oe  <= scl_c;
      sda_oe  <= sda_c;
      busy    <= (state != S_DONE) && (state != S_ERROR);
      enabled <= (state == S_DONE);
      error   <= (state == S_ERROR);
    end
  end

endmodule

// File: doc/adau1761_init.md
# adau1761_init

Power-up configuration sequencer for the ADAU1761 codec. It walks a fixed table of register writes and issues each one as an I2C write over an open-drain SCL/SDA pair. It retries writes the codec does not acknowledge. When the whole table has been written it raises `enabled`, which gates the I2S serdes and the rest of the audio datapath.

## Interface
Parameters:
- `CLK_DIV`, 62: clk cycles per SCL quarter-period (Q); 62 gives about 400 kHz at 100 MHz.
- `STARTUP_WAIT`, 2_000_000: clk cycles to wait after reset release before the first write (codec power-up time).
- `MAX_RETRIES`, 3: additional attempts per table entry after a NACK.
- `DEV_ADDR`, 7'h38: 7-bit I2C address of the codec.
- `NUM_WRITES`, 16: number of entries in the internal `{reg_addr[15:0], data[7:0]}` table. Entry 0 is R0 (0x4000 clock control); the last entry enables the digital power and serial port blocks.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; reruns the table from entry 0. Honoured only in DONE or ERROR.
- `sda_i`  in  1  sampled SDA line.
- `scl_oe`  out  1  1 = drive SCL low; 0 = release.
- `sda_oe`  out  1  1 = drive SDA low; 0 = release.
- `busy`  out  1  sequence in progress (WAIT through GAP).
- `enabled`  out  1  codec configured; feeds the serdes enable.
- `error`  out  1  an entry exhausted its retries.
- `fail_index`  out  $clog2(NUM_WRITES)  index of the entry that failed; valid while `error`=1.

## Operation
- Reset value of all outputs is 0 (both lines released). Reset is asynchronous at any point, including mid-byte: outputs release immediately. After reset the sequencer re-enters WAIT, and the next START resynchronises the codec.
- After reset release the FSM is in WAIT. The first entry starts automatically once WAIT expires; `start` is not needed after reset.
- States:
  - WAIT: count STARTUP_WAIT cycles, then go to START with entry index 0 and retry count 0.
  - START: 2 Q.
    - Q0: sda_oe=1, scl_oe=0.
    - Q1: sda_oe=1, scl_oe=1.
    - Then go to BYTE.
  - BYTE: 4 bytes, sent MSB first: `{DEV_ADDR,1'b0}`, reg_addr[15:8], reg_addr[7:0], data.
    - Each byte is 8 data bits plus 1 ACK bit, 4 Q per bit.
    - Bit Q0: scl_oe=1; sda_oe = ~bit. During the ACK bit, sda_oe=0.
    - Q1: scl_oe=1.
    - Q2, Q3: scl_oe=0.
    - sda_i is sampled on the first clk of Q3.
    - An ACK sample of 1 is a NACK. On NACK, abandon the remaining bytes and go to STOP with a nack flag set.
  - STOP: 3 Q.
    - Q0: scl_oe=1, sda_oe=1.
    - Q1: scl_oe=0, sda_oe=1.
    - Q2: both released.
  - GAP: 4 Q with both lines released. Then:
    - nack and retry < MAX_RETRIES: retry++, go to START with the same entry.
    - nack and retries exhausted: go to ERROR and latch fail_index.
    - no nack and more entries remain: index++, retry reset to 0, go to START.
    - no nack and this was the last entry: go to DONE.
  - DONE: enabled=1, busy=0. `start` goes to START with index 0, enabled=0, busy=1. The WAIT delay is not repeated.
  - ERROR: error=1, enabled=0, busy=0. `start` clears error and goes to START with index 0.
- `start` is ignored in WAIT, START, BYTE, STOP and GAP.
- The Q counter is $clog2(CLK_DIV) bits and wraps from CLK_DIV-1 to 0, advancing the phase.
- The bit counter counts 0..8 within a byte; the byte counter counts 0..3. Both are internal.
- Outputs are registered; no combinational path exists from sda_i to any output.

## Timing
- A successful write takes 2+144+3+4 = 153 Q = 153·CLK_DIV cycles.
- A NACK on byte k (0..3) shortens the write to 2+36·(k+1)+3+4 Q.
- Reset release to the first sda_oe rise: STARTUP_WAIT cycles, ±1.
- `enabled` rises on the clk after the final GAP ends.
- `enabled` falls on the clk after an accepted `start`.
- busy/enabled/error change only on state transitions.
- SDA changes only while SCL is low, except during START and STOP.

## Test plan
- Nominal run (CLK_DIV=4, STARTUP_WAIT=10, I2C slave model ACKs everything) → 16 writes; the decoded bus shows 0x70, then the table bytes in order; enabled=1 at cycle 10+16·612 (±2).
- NACK once on entry 3, byte 2 → entry 3 is resent in full, the sequence completes, enabled=1, error=0.
- Slave NACKs the address byte always → entry 0 is attempted 4 times, then error=1, fail_index=0, enabled=0, busy=0; a `start` pulse then retries from entry 0.
- Reset asserted mid-byte on entry 5 → scl_oe=sda_oe=0 in the same cycle; after release, WAIT runs again and the sequence restarts at entry 0.
- `start` pulsed during BYTE → ignored, with no change in bus trace. `start` pulsed in DONE → enabled drops the next clk, the table is rewritten without WAIT, and enabled re-asserts.
- Bus checker throughout: SDA never toggles while SCL is released except at START and STOP; each SCL low and high phase lasts exactly 2·CLK_DIV cycles.
